// File: rtl/core_pkg.sv
// Shared write-back definitions: requester indices, FSM state encoding and
// register-address width for the core write-back path.
package core_pkg;

   localparam int REG_ADDR_W = 5;

   localparam int WB_ALU = 0;
   localparam int WB_LSU = 1;
   localparam int WB_CSR = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } wb_state_e;

endpackage

// File: rtl/core_rr_arb.sv
// NUM_REQ-way round-robin arbiter: searches upward from the slot after
// last_grant, wrapping at NUM_REQ-1, and returns a one-hot grant plus its index.
module core_rr_arb #(
   parameter int NUM_REQ = 3,
   parameter int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDXW-1:0]    last_grant,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDXW-1:0]    gnt_idx
);

   logic            found;
   logic [IDXW-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDXW'((int'(last_grant) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            found      = 1'b1;
            gnt[idx]   = 1'b1;
            gnt_idx    = idx;
         end
      end
   end

endmodule

// File: rtl/core_wb_arb.sv
// Register-file write-back arbiter with one-cycle capture and optional
// pending-write scoreboard (enabled by defining CORE_WB_SCOREBOARD_EN).
module core_wb_arb
   import core_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [5*NUM_REQ-1:0]       req_rd_addr,
   input  logic [XLEN*NUM_REQ-1:0]    req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       wen,
   output logic [REG_ADDR_W-1:0]      rd_addr,
   output logic [XLEN-1:0]            rd_din,
   input  logic                       wb_done,
   input  logic                       alloc_valid,
   input  logic [REG_ADDR_W-1:0]      alloc_rd,
   input  logic [REG_ADDR_W-1:0]      rs1_addr,
   input  logic [REG_ADDR_W-1:0]      rs2_addr,
   output logic                       rs1_busy,
   output logic                       rs2_busy
);

   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   wb_state_e                            state;
   logic [IDXW-1:0]                      last_grant, gnt_idx;
   logic [NUM_REQ-1:0]                   gnt, req_gated;
   logic [NUM_REQ-1:0][REG_ADDR_W-1:0]   addr_v;
   logic [NUM_REQ-1:0][XLEN-1:0]         data_v;
   logic                                 can_grant, accept;

   assign addr_v = req_rd_addr;
   assign data_v = req_data;

   // A captured rd=0 write never raises wen, so it retires as if acknowledged.
   assign can_grant = rst_n && ((state == IDLE) || !wen || wb_done);
   assign req_gated = can_grant ? req_valid : '0;

   core_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .IDXW    (IDXW)
   ) u_rr (
      .req        (req_gated),
      .last_grant (last_grant),
      .gnt        (gnt),
      .gnt_idx    (gnt_idx)
   );

   assign req_ready = gnt;
   assign accept    = |gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wen        <= 1'b0;
         rd_addr    <= '0;
         rd_din     <= '0;
         last_grant <= IDXW'(NUM_REQ - 1);
      end else if (accept) begin
         state      <= WRITE;
         wen        <= (addr_v[gnt_idx] != '0);
         rd_addr    <= addr_v[gnt_idx];
         rd_din     <= data_v[gnt_idx];
         last_grant <= gnt_idx;
      end else if ((state == WRITE) && (wb_done || !wen)) begin
         state <= IDLE;
         wen   <= 1'b0;
      end
   end

`ifdef CORE_WB_SCOREBOARD_EN
   logic [31:0] busy, busy_nxt;

   // Set is applied after clear so a same-cycle alloc of a retiring rd wins.
   always_comb begin
      busy_nxt = busy;
      if (wen && wb_done) busy_nxt[rd_addr] = 1'b0;
      if (alloc_valid)    busy_nxt[alloc_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

   assign rs1_busy = busy[rs1_addr];
   assign rs2_busy = busy[rs2_addr];
`else
   logic unused_sb;
   assign unused_sb = ^{alloc_valid, alloc_rd, rs1_addr, rs2_addr};
   assign rs1_busy  = 1'b0;
   assign rs2_busy  = 1'b0;
`endif

endmodule
